// File: rtl/edsac_ctrl_pkg.sv
// Shared EDSAC main-control definitions: sequencer state encoding and drum timing constants.
package edsac_ctrl_pkg;

   localparam int unsigned MINOR_CYCLE_LEN = 36;
   localparam int unsigned MAJOR_CYCLE_LEN = 16;

   typedef enum logic [3:0] {
      StIdle,
      StSync1,
      StSearch1,
      StXfer1,
      StDecide,
      StSync2,
      StSearch2,
      StXfer2,
      StExec
   } seq_state_e;

   function automatic logic is_stage1(input seq_state_e s);
      return (s == StSync1) || (s == StSearch1) || (s == StXfer1);
   endfunction

   function automatic logic is_stage2(input seq_state_e s);
      return (s == StDecide) || (s == StSync2) || (s == StSearch2) || (s == StXfer2) ||
             (s == StExec);
   endfunction

endpackage

// File: rtl/mc_timeout.sv
// Saturating d0-pulse counter; hit_o flags the d0 that brings the count to Limit.
module mc_timeout #(
   parameter int unsigned Width = 5,
   parameter int unsigned Limit = 17
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   input  logic d0_i,
   output logic hit_o
);

   localparam logic [Width-1:0] LimitM1  = Width'(Limit - 1);
   localparam logic [Width-1:0] CountMax = '1;

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && d0_i && (count_q != CountMax)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Fires on the counting d0 itself, so the caller can react in the same clk.
   assign hit_o = en_i & d0_i & (count_q >= LimitM1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/stage_sequencer.sv
// EDSAC two-stage order cycle sequencer: order fetch, operand fetch/store, execute supervision.
module stage_sequencer
   import edsac_ctrl_pkg::*;
#(
   parameter int unsigned MAX_SEARCH   = 17,
   parameter int unsigned EXEC_TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic stop,
   input  logic d0,
   input  logic cu_gate_pos,
   input  logic mem_order,
   input  logic multi_cycle,
   input  logic exec_done,
   output logic s1,
   output logic stage1,
   output logic stage2,
   output logic ot_load,
   output logic sct_inc,
   output logic halted,
   output logic search_err,
   output logic exec_err
);

   localparam int unsigned SearchW = 5;
   localparam int unsigned ExecW   = $clog2(EXEC_TIMEOUT) + 1;

   seq_state_e state_q, state_d, end_state;
   logic stop_pend_q, stop_pend_d;
   logic mc_q, mc_d;
   logic gate_prev_q, gate_prev_d;
   logic s1_q, s1_d;
   logic sct_inc_q, sct_inc_d;
   logic search_err_q, search_err_d;
   logic exec_err_q, exec_err_d;
   logic stage1_q, stage2_q, halted_q;
   logic in_search, in_exec, search_hit, exec_hit, gate_rise, gate_fall;

   assign in_search = (state_q == StSearch1) || (state_q == StSearch2);
   assign in_exec   = (state_q == StExec);
   assign gate_rise = cu_gate_pos & ~gate_prev_q;
   assign gate_fall = ~cu_gate_pos;
   // A stop arriving on the very clk the order ends still takes effect.
   assign end_state = (stop_pend_q || stop) ? StIdle : StSync1;

   mc_timeout #(
      .Width (SearchW),
      .Limit (MAX_SEARCH)
   ) u_search_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (!in_search),
      .en_i  (in_search),
      .d0_i  (d0),
      .hit_o (search_hit)
   );

   mc_timeout #(
      .Width (ExecW),
      .Limit (EXEC_TIMEOUT)
   ) u_exec_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (!in_exec),
      .en_i  (in_exec),
      .d0_i  (d0),
      .hit_o (exec_hit)
   );

   always_comb begin
      state_d      = state_q;
      stop_pend_d  = stop_pend_q;
      mc_d         = mc_q;
      gate_prev_d  = cu_gate_pos;
      s1_d         = 1'b0;
      sct_inc_d    = 1'b0;
      search_err_d = search_err_q;
      exec_err_d   = exec_err_q;

      if ((state_q != StIdle) && stop) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               search_err_d = 1'b0;
               exec_err_d   = 1'b0;
               stop_pend_d  = 1'b0;
               state_d      = StSync1;
            end
         end
         StSync1, StSync2: begin
            // Pretend the gate was high so a gate already up on SEARCH entry is no edge.
            gate_prev_d = 1'b1;
            if (d0) begin
               s1_d    = 1'b1;
               state_d = (state_q == StSync1) ? StSearch1 : StSearch2;
            end
         end
         StSearch1, StSearch2: begin
            if (gate_rise) begin
               state_d = (state_q == StSearch1) ? StXfer1 : StXfer2;
            end else if (search_hit) begin
               search_err_d = 1'b1;
               state_d      = StIdle;
            end
         end
         StXfer1: begin
            if (gate_fall) begin
               sct_inc_d = 1'b1;
               state_d   = StDecide;
            end
         end
         StDecide: begin
            mc_d = multi_cycle;
            if (mem_order) begin
               state_d = StSync2;
            end else if (multi_cycle) begin
               state_d = StExec;
            end else begin
               state_d = end_state;
            end
         end
         StXfer2: begin
            if (gate_fall) begin
               state_d = mc_q ? StExec : end_state;
            end
         end
         StExec: begin
            if (exec_done) begin
               state_d = end_state;
            end else if (exec_hit) begin
               exec_err_d = 1'b1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         stop_pend_q  <= 1'b0;
         mc_q         <= 1'b0;
         gate_prev_q  <= 1'b0;
         s1_q         <= 1'b0;
         sct_inc_q    <= 1'b0;
         search_err_q <= 1'b0;
         exec_err_q   <= 1'b0;
         stage1_q     <= 1'b0;
         stage2_q     <= 1'b0;
         halted_q     <= 1'b1;
      end else begin
         state_q      <= state_d;
         stop_pend_q  <= stop_pend_d;
         mc_q         <= mc_d;
         gate_prev_q  <= gate_prev_d;
         s1_q         <= s1_d;
         sct_inc_q    <= sct_inc_d;
         search_err_q <= search_err_d;
         exec_err_q   <= exec_err_d;
         stage1_q     <= is_stage1(state_d);
         stage2_q     <= is_stage2(state_d);
         halted_q     <= (state_d == StIdle);
      end
   end

   assign s1         = s1_q;
   assign stage1     = stage1_q;
   assign stage2     = stage2_q;
   assign ot_load    = (state_q == StXfer1) & cu_gate_pos;
   assign sct_inc    = sct_inc_q;
   assign halted     = halted_q;
   assign search_err = search_err_q;
   assign exec_err   = exec_err_q;

endmodule
